// File: rtl/piso_left_serializer.sv
// piso_left_serializer
// Parallel-in serial-out transmitter intended to feed a left-shifting SIPO.
// A WIDTH-bit word is accepted through a valid/ready handshake and shifted
// out one bit per clock, MSB first by default (LSB first when LSB_FIRST=1).
// Back-to-back words stream with no idle bubble; the last bit of each word
// is flagged with frame_done.
//
// Ports:
//   clk              in   system clock, rising-edge active
//   reset            in   asynchronous active-low reset
//   parallel_data_in in   word to serialize, sampled only on an accepted load
//   load_valid       in   upstream offers a word
//   load_ready       out  block can accept a word this cycle
//   serial_data_out  out  serial bit stream
//   serial_valid     out  serial_data_out carries a data bit
//   frame_done       out  last bit of a word is on serial_data_out
module piso_left_serializer #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_data_out,
    output logic             serial_valid,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               last_bit;
    logic               accept;
    logic               head_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            count     <= count_next;
        end
    end

    assign last_bit = (state == SHIFT) && (count == LAST_BIT);

    // Ready is gated by reset so the upstream sees no acceptance while the
    // block is held in reset, even though the state already reads IDLE.
    assign load_ready = reset && ((state == IDLE) || last_bit);
    assign accept     = load_valid && load_ready;

    assign head_bit = (LSB_FIRST != 0) ? shift_reg[0] : shift_reg[WIDTH-1];

    assign serial_valid    = (state == SHIFT);
    assign serial_data_out = (state == SHIFT) && head_bit;
    assign frame_done      = last_bit;

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        count_next = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next = parallel_data_in;
                    count_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // A load on the last-bit edge chains the next word with
                    // no gap; otherwise drop back to IDLE with a clean register.
                    if (accept) begin
                        shift_next = parallel_data_in;
                        count_next = '0;
                        state_next = SHIFT;
                    end else begin
                        shift_next = '0;
                        count_next = '0;
                        state_next = IDLE;
                    end
                end else begin
                    if (LSB_FIRST != 0) begin
                        shift_next = shift_reg >> 1;
                    end else begin
                        shift_next = shift_reg << 1;
                    end
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                shift_next = '0;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_left_serializer.sv
// Directed self-checking bench for piso_left_serializer (WIDTH=4), with one
// MSB-first and one LSB-first instance sharing the same stimulus, plus a
// downstream left-shifting SIPO register fed by the MSB-first stream.
module tb_piso_left_serializer;

    logic       clk;
    logic       reset;
    logic [3:0] data;
    logic       load_valid;

    logic       ready_m, sdo_m, sv_m, fd_m;
    logic       ready_l, sdo_l, sv_l, fd_l;

    logic [3:0] sipo;

    int checks;
    int errors;

    piso_left_serializer #(.WIDTH(4), .LSB_FIRST(0)) dut_msb (
        .clk              (clk),
        .reset            (reset),
        .parallel_data_in (data),
        .load_valid       (load_valid),
        .load_ready       (ready_m),
        .serial_data_out  (sdo_m),
        .serial_valid     (sv_m),
        .frame_done       (fd_m)
    );

    piso_left_serializer #(.WIDTH(4), .LSB_FIRST(1)) dut_lsb (
        .clk              (clk),
        .reset            (reset),
        .parallel_data_in (data),
        .load_valid       (load_valid),
        .load_ready       (ready_l),
        .serial_data_out  (sdo_l),
        .serial_valid     (sv_l),
        .frame_done       (fd_l)
    );

    // Downstream left-shifting SIPO model.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sipo <= '0;
        else if (sv_m) sipo <= {sipo[2:0], sdo_m};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_m(input string tag, input logic d, input logic v,
                            input logic f, input logic r);
        check({tag, ".data"},  32'(sdo_m),   32'(d));
        check({tag, ".valid"}, 32'(sv_m),    32'(v));
        check({tag, ".done"},  32'(fd_m),    32'(f));
        check({tag, ".ready"}, 32'(ready_m), 32'(r));
    endtask

    task automatic expect_l(input string tag, input logic d, input logic v,
                            input logic f, input logic r);
        check({tag, ".data"},  32'(sdo_l),   32'(d));
        check({tag, ".valid"}, 32'(sv_l),    32'(v));
        check({tag, ".done"},  32'(fd_l),    32'(f));
        check({tag, ".ready"}, 32'(ready_l), 32'(r));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        data       = '0;
        load_valid = 1'b0;

        // Reset hold with random inputs.
        for (int i = 0; i < 4; i++) begin
            data       = 4'($urandom_range(0, 15));
            load_valid = 1'($urandom_range(0, 1));
            tick();
            expect_m("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        load_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check("rst_release.ready", 32'(ready_m), 32'd1);
        tick();
        expect_m("idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Single word 1101, MSB first.
        data = 4'b1101; load_valid = 1'b1;
        tick(); expect_m("single.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        load_valid = 1'b0; data = 4'b0000;
        tick(); expect_m("single.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); expect_m("single.b3", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); expect_m("single.b4", 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); expect_m("single.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check("single.sipo", 32'(sipo), 32'hD);

        // Back-to-back 1101 then 0110.
        data = 4'b1101; load_valid = 1'b1;
        tick(); expect_m("b2b.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        data = 4'b0110;
        tick(); expect_m("b2b.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); expect_m("b2b.b3", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); expect_m("b2b.b4", 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); expect_m("b2b.b5", 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b.sipo1", 32'(sipo), 32'hD);
        load_valid = 1'b0; data = 4'b1111;
        tick(); expect_m("b2b.b6", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); expect_m("b2b.b7", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); expect_m("b2b.b8", 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); expect_m("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b.sipo2", 32'(sipo), 32'h6);

        // Busy ignore: 1010 with a 0000 offer during bits 2-3.
        data = 4'b1010; load_valid = 1'b1;
        tick(); expect_m("busy.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        data = 4'b0000;
        tick(); expect_m("busy.b2", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); expect_m("busy.b3", 1'b1, 1'b1, 1'b0, 1'b0);
        load_valid = 1'b0;
        tick(); expect_m("busy.b4", 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); expect_m("busy.idle1", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_m("busy.idle2", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word after two bits of 1111.
        data = 4'b1111; load_valid = 1'b1;
        tick(); expect_m("midrst.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        load_valid = 1'b0;
        tick(); expect_m("midrst.b2", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 expect_m("midrst.async", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); expect_m("midrst.hold", 1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        tick(); expect_m("midrst.after1", 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); expect_m("midrst.after2", 1'b0, 1'b0, 1'b0, 1'b1);

        // LSB-first instance: 1101 -> 1,0,1,1.
        data = 4'b1101; load_valid = 1'b1;
        tick(); expect_l("lsb.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        load_valid = 1'b0; data = 4'b0000;
        tick(); expect_l("lsb.b2", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); expect_l("lsb.b3", 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); expect_l("lsb.b4", 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); expect_l("lsb.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
